// File: rtl/nasti_tc_pkg.sv
// Shared types, constants and the data-pattern rule for the DDR traffic checker.
package nasti_tc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // 32-bit lane `lane` of the beat at byte address `addr`: (addr + 4*lane) ^ seed.
    function automatic logic [31:0] pattern(input logic [63:0] addr,
                                            input logic [31:0] seed,
                                            input int unsigned lane);
        logic [63:0] lane_addr;
        lane_addr = addr + 64'(lane) * 64'd4;
        return lane_addr[31:0] ^ seed;
    endfunction

endpackage

// File: rtl/nasti_if.sv
// NASTI (AXI4) bundle between the traffic checker and the memory controller.
interface nasti_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;

    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;

    logic                    r_valid;
    logic                    r_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

endinterface

// File: rtl/nasti_tc_pattern.sv
// Combinational expected-word generator: one pattern lane per 32 bits of the bus.
module nasti_tc_pattern
    import nasti_tc_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 64,
    parameter logic [31:0] SEED   = 32'hA5A5_5A5A
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);
    localparam int LANES = DATA_W / 32;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign word[32*i +: 32] = pattern(64'(addr), SEED, unsigned'(i));
    end

endmodule

// File: rtl/nasti_ddrx_traffic_chk.sv
// Write-then-read-back NASTI traffic checker for DDR bring-up: one transaction in flight.
module nasti_ddrx_traffic_chk
    import nasti_tc_pkg::*;
#(
    parameter int                            C_NASTI_ID_WIDTH   = 1,
    parameter int                            C_NASTI_ADDR_WIDTH = 32,
    parameter int                            C_NASTI_DATA_WIDTH = 64,
    parameter int                            C_NASTI_USER_WIDTH = 1,
    parameter logic [C_NASTI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            C_BURST_LEN        = 16,
    parameter int                            C_NUM_BURSTS       = 64,
    parameter logic [31:0]                   C_SEED             = 32'hA5A5_5A5A,
    parameter bit                            C_LOOP             = 1'b0
) (
    input  logic        core_clk,
    input  logic        core_arstn,
    input  logic        start,
    nasti_if.master     m_nasti,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic        irq
);
    localparam int ADDR_W  = C_NASTI_ADDR_WIDTH;
    localparam int BYTES   = C_NASTI_DATA_WIDTH / 8;
    localparam int BEAT_W  = $clog2(C_BURST_LEN + 1);
    localparam int BURST_W = $clog2(C_NUM_BURSTS + 1);

    localparam logic [BEAT_W-1:0]  LAST_BEAT    = BEAT_W'(C_BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST   = BURST_W'(C_NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0]  BURST_STRIDE = ADDR_W'(C_BURST_LEN * BYTES);
    localparam logic [ADDR_W-1:0]  BEAT_STRIDE  = ADDR_W'(BYTES);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                        state, state_nxt;
    logic [BURST_W-1:0]            burst;
    logic [BEAT_W-1:0]             beat;
    logic [ADDR_W-1:0]             burst_addr, beat_addr;
    logic [C_NASTI_DATA_WIDTH-1:0] wr_word, exp_word;
    logic                          last_beat, last_burst;
    logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                          b_bad, r_bad, err_hit;
    logic [15:0]                   err_nxt;

    assign burst_addr = C_BASE_ADDR + ADDR_W'(burst) * BURST_STRIDE;
    assign beat_addr  = burst_addr + ADDR_W'(beat) * BEAT_STRIDE;
    assign last_beat  = (beat == LAST_BEAT);
    assign last_burst = (burst == LAST_BURST);

    nasti_tc_pattern #(.ADDR_W(ADDR_W), .DATA_W(C_NASTI_DATA_WIDTH), .SEED(C_SEED)) u_wr_pat (
        .addr (beat_addr),
        .word (wr_word)
    );

    nasti_tc_pattern #(.ADDR_W(ADDR_W), .DATA_W(C_NASTI_DATA_WIDTH), .SEED(C_SEED)) u_rd_pat (
        .addr (beat_addr),
        .word (exp_word)
    );

    // Channel drives are decoded from state, so reset clears every valid/ready at once.
    assign m_nasti.aw_valid  = (state == WR_ADDR);
    assign m_nasti.aw_id     = '0;
    assign m_nasti.aw_addr   = burst_addr;
    assign m_nasti.aw_len    = 8'(C_BURST_LEN - 1);
    assign m_nasti.aw_size   = 3'($clog2(BYTES));
    assign m_nasti.aw_burst  = BURST_INCR;
    assign m_nasti.aw_lock   = 1'b0;
    assign m_nasti.aw_cache  = 4'd0;
    assign m_nasti.aw_prot   = 3'd0;
    assign m_nasti.aw_qos    = 4'd0;
    assign m_nasti.aw_region = 4'd0;
    assign m_nasti.aw_user   = '0;

    assign m_nasti.w_valid   = (state == WR_DATA);
    assign m_nasti.w_data    = wr_word;
    assign m_nasti.w_strb    = '1;
    assign m_nasti.w_last    = last_beat;
    assign m_nasti.w_user    = '0;

    assign m_nasti.b_ready   = (state == WR_RESP);

    assign m_nasti.ar_valid  = (state == RD_ADDR);
    assign m_nasti.ar_id     = '0;
    assign m_nasti.ar_addr   = burst_addr;
    assign m_nasti.ar_len    = 8'(C_BURST_LEN - 1);
    assign m_nasti.ar_size   = 3'($clog2(BYTES));
    assign m_nasti.ar_burst  = BURST_INCR;
    assign m_nasti.ar_lock   = 1'b0;
    assign m_nasti.ar_cache  = 4'd0;
    assign m_nasti.ar_prot   = 3'd0;
    assign m_nasti.ar_qos    = 4'd0;
    assign m_nasti.ar_region = 4'd0;
    assign m_nasti.ar_user   = '0;

    assign m_nasti.r_ready   = (state == RD_DATA);

    assign aw_hs = m_nasti.aw_valid && m_nasti.aw_ready;
    assign w_hs  = m_nasti.w_valid  && m_nasti.w_ready;
    assign b_hs  = m_nasti.b_valid  && m_nasti.b_ready;
    assign ar_hs = m_nasti.ar_valid && m_nasti.ar_ready;
    assign r_hs  = m_nasti.r_valid  && m_nasti.r_ready;

    assign b_bad = (m_nasti.b_resp != RESP_OKAY) || (m_nasti.b_id != '0);
    assign r_bad = (m_nasti.r_data != exp_word) || (m_nasti.r_resp != RESP_OKAY) ||
                   (m_nasti.r_id != '0) || (m_nasti.r_last != last_beat);
    assign err_hit = (b_hs && b_bad) || (r_hs && r_bad);
    assign err_nxt = err_hit ? sat_inc(err_cnt) : err_cnt;

    // Next-state: read bursts end on the beat count alone, never on r_last.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WR_ADDR;
            WR_ADDR: if (aw_hs) state_nxt = WR_DATA;
            WR_DATA: if (w_hs && last_beat) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = last_burst ? RD_ADDR : WR_ADDR;
            RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
            RD_DATA: if (r_hs && last_beat) state_nxt = last_burst ? DONE : RD_ADDR;
            DONE: begin
                if (C_LOOP && start) state_nxt = WR_ADDR;
                else if (!start)     state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and status flags; done/pass only change on pass start or completion.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state   <= IDLE;
            burst   <= '0;
            beat    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
            irq     <= 1'b0;
        end else begin
            state   <= state_nxt;
            irq     <= (state_nxt == DONE) && (state != DONE);
            err_cnt <= err_nxt;
            case (state)
                IDLE: if (start) begin
                    done    <= 1'b0;
                    pass    <= 1'b0;
                    err_cnt <= '0;
                    burst   <= '0;
                    beat    <= '0;
                    busy    <= 1'b1;
                end
                WR_DATA: if (w_hs) beat <= last_beat ? '0 : beat + 1'b1;
                WR_RESP: if (b_hs) burst <= last_burst ? '0 : burst + 1'b1;
                RD_DATA: if (r_hs) begin
                    beat <= last_beat ? '0 : beat + 1'b1;
                    if (last_beat) burst <= last_burst ? '0 : burst + 1'b1;
                    if (last_beat && last_burst) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_nxt == 16'd0);
                    end
                end
                DONE: if (C_LOOP && start) begin
                    err_cnt <= '0;
                    burst   <= '0;
                    beat    <= '0;
                    busy    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nasti_ddrx_traffic_chk.sv
// Bench: one-shot instance (0) and looping instance (1), each on a loopback memory slave.
module tb_nasti_ddrx_traffic_chk;
    localparam int          LEN  = 4;
    localparam int          NB   = 2;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] SEED = 32'hA5A5_5A5A;

    logic             core_clk = 1'b0;
    logic             core_arstn;
    logic [1:0]       start_v;
    logic [1:0]       busy_v, done_v, pass_v, irq_v;
    logic [1:0][15:0] err_v;

    int n_chk = 0;
    int n_err = 0;

    // fault knobs, applied by slave 0 only; -1 disables
    int corrupt_at = -1;
    int berr_at    = -1;
    int rdrop_at   = -1;
    bit bp         = 1'b0;

    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input logic [31:0] a);
        logic [31:0] l0, l1;
        l0 = a ^ SEED;
        l1 = (a + 32'd4) ^ SEED;
        return {l1, l0};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_blk
        localparam bit INJ = (g == 0);

        nasti_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(64), .USER_WIDTH(1)) bus ();

        nasti_ddrx_traffic_chk #(
            .C_NASTI_ID_WIDTH(1), .C_NASTI_ADDR_WIDTH(32), .C_NASTI_DATA_WIDTH(64),
            .C_NASTI_USER_WIDTH(1), .C_BASE_ADDR(BASE), .C_BURST_LEN(LEN),
            .C_NUM_BURSTS(NB), .C_SEED(SEED), .C_LOOP(g == 1)
        ) dut (
            .core_clk   (core_clk),
            .core_arstn (core_arstn),
            .start      (start_v[g]),
            .m_nasti    (bus),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .pass       (pass_v[g]),
            .err_cnt    (err_v[g]),
            .irq        (irq_v[g])
        );

        // slave state
        logic        aw_rdy, w_rdy, ar_rdy, bv, rv;
        logic [1:0]  bresp;
        logic [31:0] wa, ra;
        int          wcnt, rcnt, wb_tot, rb_tot, r_tot;
        logic [63:0] mem [64];

        assign bus.aw_ready = aw_rdy;
        assign bus.w_ready  = w_rdy;
        assign bus.ar_ready = ar_rdy;
        assign bus.b_valid  = bv;
        assign bus.b_resp   = bresp;
        assign bus.b_id     = 1'b0;
        assign bus.b_user   = 1'b0;
        assign bus.r_valid  = rv;
        assign bus.r_id     = 1'b0;
        assign bus.r_resp   = 2'b00;
        assign bus.r_user   = 1'b0;
        assign bus.r_data   = mem[6'((ra >> 3) + 32'(rcnt))] ^ {63'd0, INJ && (r_tot == corrupt_at)};
        assign bus.r_last   = (rcnt == LEN - 1) && !(INJ && (rb_tot == rdrop_at));

        // loopback memory slave with optional ready backpressure and fault injection
        always @(posedge core_clk or negedge core_arstn) begin
            if (!core_arstn) begin
                aw_rdy <= 1'b1; w_rdy <= 1'b1; ar_rdy <= 1'b1;
                bv <= 1'b0; bresp <= 2'b00; rv <= 1'b0;
                wa <= '0; ra <= '0; wcnt <= 0; rcnt <= 0;
                wb_tot <= 0; rb_tot <= 0; r_tot <= 0;
            end else begin
                aw_rdy <= (INJ && bp) ? ($urandom_range(9, 0) < 3) : 1'b1;
                w_rdy  <= (INJ && bp) ? ($urandom_range(9, 0) < 3) : 1'b1;
                ar_rdy <= (INJ && bp) ? ($urandom_range(9, 0) < 3) : 1'b1;
                if (bus.aw_valid && bus.aw_ready) begin
                    wa <= bus.aw_addr;
                    wcnt <= 0;
                end
                if (bus.w_valid && bus.w_ready) begin
                    mem[6'((wa >> 3) + 32'(wcnt))] <= bus.w_data;
                    wcnt <= wcnt + 1;
                    if (wcnt == LEN - 1) begin
                        bv <= 1'b1;
                        bresp <= (INJ && (wb_tot == berr_at)) ? 2'b10 : 2'b00;
                        wb_tot <= wb_tot + 1;
                    end
                end
                if (bv && bus.b_ready) bv <= 1'b0;
                if (bus.ar_valid && bus.ar_ready) begin
                    ra <= bus.ar_addr;
                    rcnt <= 0;
                    rv <= 1'b1;
                end
                if (rv && bus.r_ready) begin
                    r_tot <= r_tot + 1;
                    if (rcnt == LEN - 1) begin
                        rv <= 1'b0;
                        rb_tot <= rb_tot + 1;
                    end else begin
                        rcnt <= rcnt + 1;
                    end
                end
            end
        end

        // monitor / reference model state
        int          aw_n, w_n, ar_n, r_n, irq_n, m_err;
        logic        aw_stall, w_stall, ar_stall;
        logic [31:0] aw_prev, ar_prev;
        logic [63:0] w_prev_data;
        logic        w_prev_last;

        // protocol checks and expected error tally, sampled on the falling edge
        always @(negedge core_clk) begin
            if (!core_arstn) begin
                aw_n <= 0; w_n <= 0; ar_n <= 0; r_n <= 0; irq_n <= 0; m_err <= 0;
                aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
            end else begin
                if (aw_stall) chk("aw_hold", {bus.aw_valid, bus.aw_addr}, {1'b1, aw_prev});
                if (w_stall)  chk("w_hold", {bus.w_valid, bus.w_last}, {1'b1, w_prev_last});
                if (w_stall)  chk("w_hold_data", bus.w_data, w_prev_data);
                if (ar_stall) chk("ar_hold", {bus.ar_valid, bus.ar_addr}, {1'b1, ar_prev});
                aw_stall <= bus.aw_valid && !bus.aw_ready;
                w_stall  <= bus.w_valid && !bus.w_ready;
                ar_stall <= bus.ar_valid && !bus.ar_ready;
                aw_prev <= bus.aw_addr; ar_prev <= bus.ar_addr;
                w_prev_data <= bus.w_data; w_prev_last <= bus.w_last;
                if (bus.w_valid) chk("aw_w_overlap", bus.aw_valid, 0);
                if (bus.aw_valid && bus.aw_ready) begin
                    chk("aw_addr", bus.aw_addr, BASE + 32'((aw_n % NB) * LEN * 8));
                    chk("aw_fields", {bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_id},
                        {8'(LEN - 1), 3'd3, 2'b01, 1'b0});
                    aw_n <= aw_n + 1;
                end
                if (bus.w_valid && bus.w_ready) begin
                    chk("w_data", bus.w_data, ref_word(BASE + 32'((w_n % (LEN * NB)) * 8)));
                    chk("w_last", bus.w_last, (w_n % LEN) == LEN - 1);
                    chk("w_strb", bus.w_strb, 8'hFF);
                    w_n <= w_n + 1;
                end
                if (bus.ar_valid && bus.ar_ready) begin
                    chk("ar_addr", bus.ar_addr, BASE + 32'((ar_n % NB) * LEN * 8));
                    chk("ar_fields", {bus.ar_len, bus.ar_size, bus.ar_burst, bus.ar_id},
                        {8'(LEN - 1), 3'd3, 2'b01, 1'b0});
                    ar_n <= ar_n + 1;
                end
                if (bus.b_valid && bus.b_ready)
                    m_err <= m_err + (((bus.b_resp != 2'b00) || (bus.b_id != 1'b0)) ? 1 : 0);
                if (bus.r_valid && bus.r_ready) begin
                    m_err <= m_err + (((bus.r_data != ref_word(BASE + 32'((r_n % (LEN * NB)) * 8))) ||
                                       (bus.r_resp != 2'b00) || (bus.r_id != 1'b0) ||
                                       (bus.r_last != ((r_n % LEN) == LEN - 1))) ? 1 : 0);
                    r_n <= r_n + 1;
                end
                irq_n <= irq_n + (irq_v[g] ? 1 : 0);
            end
        end
    end

    task automatic wait_irq(input int g, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge core_clk);
            seen = irq_v[g];
        end
        chk({tag, "_irq_seen"}, seen, 1);
    endtask

    task automatic run_oneshot(input int exp_err, input string tag);
        int irq0, aw0, w0, ar0, m0;
        irq0 = g_blk[0].irq_n; aw0 = g_blk[0].aw_n; w0 = g_blk[0].w_n;
        ar0 = g_blk[0].ar_n;   m0 = g_blk[0].m_err;
        start_v[0] = 1'b1;
        @(negedge core_clk);
        chk({tag, "_busy"}, busy_v[0], 1);
        chk({tag, "_aw_latency"}, g_blk[0].bus.aw_valid, 1);
        start_v[0] = 1'b0;
        wait_irq(0, tag);
        chk({tag, "_done"}, done_v[0], 1);
        chk({tag, "_pass"}, pass_v[0], (exp_err == 0));
        chk({tag, "_err_cnt"}, err_v[0], exp_err);
        chk({tag, "_err_model"}, err_v[0], g_blk[0].m_err - m0);
        chk({tag, "_busy_end"}, busy_v[0], 0);
        @(negedge core_clk);
        chk({tag, "_irq_pulses"}, g_blk[0].irq_n - irq0, 1);
        chk({tag, "_irq_low"}, irq_v[0], 0);
        chk({tag, "_done_hold"}, {done_v[0], pass_v[0]}, {1'b1, exp_err == 0});
        chk({tag, "_aw_count"}, g_blk[0].aw_n - aw0, NB);
        chk({tag, "_w_count"}, g_blk[0].w_n - w0, NB * LEN);
        chk({tag, "_ar_count"}, g_blk[0].ar_n - ar0, NB);
    endtask

    initial begin
        bit ok;
        int irq1, w0;
        core_arstn = 1'b0;
        start_v    = 2'b00;
        repeat (3) @(negedge core_clk);
        chk("rst_valids0", {g_blk[0].bus.aw_valid, g_blk[0].bus.w_valid, g_blk[0].bus.ar_valid,
                            g_blk[0].bus.b_ready, g_blk[0].bus.r_ready}, 0);
        chk("rst_valids1", {g_blk[1].bus.aw_valid, g_blk[1].bus.w_valid, g_blk[1].bus.ar_valid,
                            g_blk[1].bus.b_ready, g_blk[1].bus.r_ready}, 0);
        chk("rst_status", {busy_v, done_v, pass_v, irq_v}, 0);
        chk("rst_err", err_v, 0);
        core_arstn = 1'b1;
        repeat (2) @(negedge core_clk);

        run_oneshot(0, "clean");

        corrupt_at = g_blk[0].r_tot + 5;
        run_oneshot(1, "corrupt");
        corrupt_at = -1;

        berr_at  = g_blk[0].wb_tot;
        rdrop_at = g_blk[0].rb_tot + 1;
        run_oneshot(2, "resp_err");
        berr_at  = -1;
        rdrop_at = -1;

        bp = 1'b1;
        run_oneshot(0, "backpressure");
        bp = 1'b0;

        // reset while the third write beat is on the bus
        w0 = g_blk[0].w_n;
        start_v[0] = 1'b1;
        @(negedge core_clk);
        start_v[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge core_clk);
            ok = g_blk[0].bus.w_valid && ((g_blk[0].w_n - w0) == 2);
        end
        chk("midrst_reach_beat2", ok, 1);
        core_arstn = 1'b0;
        #1;
        chk("midrst_valids", {g_blk[0].bus.aw_valid, g_blk[0].bus.w_valid, g_blk[0].bus.ar_valid,
                              g_blk[0].bus.b_ready, g_blk[0].bus.r_ready}, 0);
        chk("midrst_status", {busy_v[0], done_v[0], pass_v[0], irq_v[0]}, 0);
        chk("midrst_err", err_v[0], 0);
        repeat (2) @(negedge core_clk);
        core_arstn = 1'b1;
        @(negedge core_clk);
        run_oneshot(0, "after_rst");

        // looping instance with start held high
        irq1 = g_blk[1].irq_n;
        start_v[1] = 1'b1;
        wait_irq(1, "loop1");
        chk("loop1_done_pass", {done_v[1], pass_v[1], busy_v[1]}, {1'b1, 1'b1, 1'b0});
        chk("loop1_err", err_v[1], 0);
        @(negedge core_clk);
        chk("loop_restart_aw", g_blk[1].bus.aw_valid, 1);
        chk("loop_restart_addr", g_blk[1].bus.aw_addr, BASE);
        chk("loop_busy_again", busy_v[1], 1);
        chk("loop_done_kept", {done_v[1], pass_v[1]}, 2'b11);
        wait_irq(1, "loop2");
        start_v[1] = 1'b0;
        chk("loop2_done_pass", {done_v[1], pass_v[1]}, 2'b11);
        chk("loop2_err", err_v[1], 0);
        repeat (2) @(negedge core_clk);
        chk("loop_irq_pulses", g_blk[1].irq_n - irq1, 2);
        chk("loop_idle", {busy_v[1], g_blk[1].bus.aw_valid}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
